// File: rtl/toeplitz_row_sched.sv
// rtl/toeplitz_row_sched.sv - Toeplitz GF(2) row-accumulate sequencer (key fetch, row shift, acc strobes)
// Optional build macro COEFF_PREFETCH_EN: overlap the next key word read with the current word's bits.
module toeplitz_row_sched #(
  parameter int ROW_W  = 3072,
  parameter int WORD_W = 32,
  parameter int WORDS  = 128,
  parameter int AW     = 7
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  input  logic              seed_load,
  input  logic [ROW_W-1:0]  seed_in,
  input  logic              col_bit,
  output logic [AW-1:0]     coeff_addr,
  output logic              coeff_rd_en,
  input  logic [WORD_W-1:0] coeff_data,
  output logic [ROW_W-1:0]  shift_row,
  output logic              acc_clr,
  output logic              acc_xor,
  output logic              result_we,
  output logic              busy,
  output logic              done
);
  localparam int BW = (WORD_W > 2) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FETCH, S_WAIT, S_BITS, S_WRITE, S_DONE} state_t;

  state_t            state;
  logic [AW-1:0]     word_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [WORD_W-1:0] coeff_reg;
  logic              last_bit;
  logic              last_word;

  assign last_bit  = (bit_cnt == BW'(WORD_W - 1));
  assign last_word = (word_cnt == AW'(WORDS - 1));

  // Stall-sensitive strobes stay combinational so hold suppresses them in the same cycle.
  assign acc_xor = (state == S_BITS) && !hold && coeff_reg[WORD_W-1];

`ifdef COEFF_PREFETCH_EN
  logic              pf_issue;
  logic              rd_q;
  logic [WORD_W-1:0] next_buf;

  assign pf_issue    = (state == S_BITS) && !hold && (bit_cnt == BW'(WORD_W - 2)) && !last_word;
  assign coeff_rd_en = ((state == S_FETCH) && !hold) || pf_issue;
  assign coeff_addr  = pf_issue ? word_cnt + 1'b1 : word_cnt;

  // Read data lands in next_buf regardless of hold, so a stalled last bit never loses it.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rd_q     <= 1'b0;
      next_buf <= '0;
    end else begin
      rd_q <= coeff_rd_en;
      if (rd_q) next_buf <= coeff_data;
    end
  end
`else
  assign coeff_rd_en = (state == S_FETCH) && !hold;
  assign coeff_addr  = word_cnt;
`endif

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      word_cnt  <= '0;
      bit_cnt   <= '0;
      coeff_reg <= '0;
      shift_row <= '0;
      acc_clr   <= 1'b0;
      result_we <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      acc_clr   <= 1'b0;
      result_we <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (seed_load) shift_row <= seed_in;
          if (start) begin
            state   <= S_CLR;
            acc_clr <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_CLR: begin
          word_cnt <= '0;
          bit_cnt  <= '0;
          state    <= S_FETCH;
        end
        S_FETCH: if (!hold) state <= S_WAIT;
        S_WAIT: begin
          coeff_reg <= coeff_data;
          bit_cnt   <= '0;
          state     <= S_BITS;
        end
        S_BITS: if (!hold) begin
          coeff_reg <= coeff_reg << 1;
          shift_row <= {shift_row[ROW_W-2:0], col_bit};
          bit_cnt   <= bit_cnt + 1'b1;
          if (last_bit) begin
            bit_cnt <= '0;
            if (last_word) begin
              state     <= S_WRITE;
              result_we <= 1'b1;
            end else begin
              word_cnt <= word_cnt + 1'b1;
`ifdef COEFF_PREFETCH_EN
              coeff_reg <= rd_q ? coeff_data : next_buf;
`else
              state <= S_FETCH;
`endif
            end
          end
        end
        S_WRITE: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_toeplitz_row_sched.sv
// tb/tb_toeplitz_row_sched.sv - directed bench for toeplitz_row_sched (small config plus one default-size run)
// Optional build macro COEFF_PREFETCH_EN selects the prefetch timing expectations.
module tb_toeplitz_row_sched;
`ifdef COEFF_PREFETCH_EN
  localparam int DONE_CYC = 13;
  localparam int BIG_DONE = 4101;
  localparam int H_BITS   = 10;
`else
  localparam int DONE_CYC = 15;
  localparam int BIG_DONE = 4355;
  localparam int H_BITS   = 8;
`endif

  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, hold = 1'b0, seed_load = 1'b0, col_bit = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic [0:0] coeff_addr;
  logic coeff_rd_en;
  logic [3:0] coeff_data = 4'h0;
  logic [7:0] shift_row;
  logic acc_clr, acc_xor, result_we, busy, done;

  logic start_b = 1'b0;
  logic [6:0] coeff_addr_b;
  logic coeff_rd_en_b;
  logic [31:0] coeff_data_b = 32'h0;
  logic [3071:0] shift_row_b;
  logic acc_clr_b, acc_xor_b, result_we_b, busy_b, done_b;

  logic [3:0] mem [2];
  logic [7:0] acc = 8'h00, res = 8'h00;
  int we_cnt = 0, xor_cnt = 0, done_cnt = 0, viol = 0;
  int clr_b_cnt = 0, xor_b_cnt = 0, we_b_cnt = 0;
  int checks = 0, failures = 0;

  always #5 clk_in = ~clk_in;

  toeplitz_row_sched #(.ROW_W(8), .WORD_W(4), .WORDS(2), .AW(1)) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .hold(hold), .seed_load(seed_load),
    .seed_in(seed_in), .col_bit(col_bit), .coeff_addr(coeff_addr), .coeff_rd_en(coeff_rd_en),
    .coeff_data(coeff_data), .shift_row(shift_row), .acc_clr(acc_clr), .acc_xor(acc_xor),
    .result_we(result_we), .busy(busy), .done(done));

  toeplitz_row_sched dut_big (
    .clk_in(clk_in), .rst(rst), .start(start_b), .hold(1'b0), .seed_load(1'b0),
    .seed_in({3072{1'b0}}), .col_bit(1'b1), .coeff_addr(coeff_addr_b), .coeff_rd_en(coeff_rd_en_b),
    .coeff_data(coeff_data_b), .shift_row(shift_row_b), .acc_clr(acc_clr_b), .acc_xor(acc_xor_b),
    .result_we(result_we_b), .busy(busy_b), .done(done_b));

  // Key RAMs return garbage on cycles with no read, accumulator and strobe monitors.
  always @(posedge clk_in) begin
    coeff_data   <= coeff_rd_en ? mem[coeff_addr] : 4'h5;
    coeff_data_b <= coeff_rd_en_b ? ({25'd0, coeff_addr_b} ^ 32'hA5A5_0F0F) : 32'h0;
    if (acc_clr) acc <= 8'h00;
    else if (acc_xor) acc <= acc ^ shift_row;
    if (result_we) begin
      res    <= acc;
      we_cnt <= we_cnt + 1;
    end
    if (acc_xor) xor_cnt <= xor_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (acc_clr_b) clr_b_cnt <= clr_b_cnt + 1;
    if (acc_xor_b) xor_b_cnt <= xor_b_cnt + 1;
    if (result_we_b) we_b_cnt <= we_b_cnt + 1;
  end

  always @(negedge clk_in) if (hold && coeff_rd_en) viol <= viol + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load_seed(input logic [7:0] s);
    seed_in = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  // Caller may pre-set seed_load so it coincides with start; poke > 0 re-issues start/seed_load mid-run.
  task automatic run(input logic [3:0] w0, input logic [3:0] w1, input logic cb,
                     input int h1, input int h2, input int poke, output int dcyc);
    int cyc;
    mem[0] = w0;
    mem[1] = w1;
    col_bit = cb;
    start = 1'b1;
    tick();
    start = 1'b0;
    seed_load = 1'b0;
    cyc = 1;
    dcyc = -1;
    while (cyc < 60 && dcyc < 0) begin
      hold = (h1 > 0 && cyc >= h1 && cyc < h1 + 3) || (h2 > 0 && cyc >= h2 && cyc < h2 + 3);
      start = (cyc == poke);
      seed_load = (cyc == poke);
      if (cyc == poke) seed_in = 8'h00;
      if (done) dcyc = cyc;
      else begin
        tick();
        cyc++;
      end
    end
    hold = 1'b0;
    start = 1'b0;
    seed_load = 1'b0;
  endtask

  initial begin
    int d, we0, x0, dn0, cyc, expect_x;
    mem[0] = 4'h0;
    mem[1] = 4'h0;
    #22;
    chk("rst_row", {24'd0, shift_row}, 32'h0);
    chk("rst_strobes", {26'd0, acc_clr, acc_xor, result_we, busy, done, coeff_rd_en}, 32'h0);
    chk("rst_addr", {31'd0, coeff_addr}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    load_seed(8'hA5);
    chk("seed_load", {24'd0, shift_row}, 32'hA5);

    we0 = we_cnt;
    run(4'hF, 4'h0, 1'b1, 0, 0, 0, d);
    tick();
    chk("c2_done_cyc", d, DONE_CYC);
    chk("c2_result", {24'd0, res}, 32'h56);
    chk("c2_we_count", we_cnt - we0, 1);
    chk("c2_final_row", {24'd0, shift_row}, 32'hFF);
    chk("c2_busy_after", {31'd0, busy}, 32'h0);

    seed_in = 8'hA5;
    seed_load = 1'b1;
    x0 = xor_cnt;
    run(4'h8, 4'h0, 1'b0, 0, 0, 0, d);
    tick();
    chk("c3_done_cyc", d, DONE_CYC);
    chk("c3_result", {24'd0, res}, 32'hA5);
    chk("c3_xor_count", xor_cnt - x0, 1);
    chk("c3_final_row", {24'd0, shift_row}, 32'h00);

    load_seed(8'hA5);
    run(4'hF, 4'h0, 1'b1, 2, H_BITS, 0, d);
    tick();
    chk("c4_done_cyc", d, DONE_CYC + 6);
    chk("c4_result", {24'd0, res}, 32'h56);
    chk("c4_rd_during_hold", viol, 0);

    load_seed(8'hA5);
    mem[0] = 4'hF;
    mem[1] = 4'h0;
    col_bit = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("c5_row_zero", {24'd0, shift_row}, 32'h0);
    chk("c5_strobes_zero", {26'd0, acc_clr, acc_xor, result_we, busy, done, coeff_rd_en}, 32'h0);
    we0 = we_cnt;
    dn0 = done_cnt;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("c5_no_done", done_cnt - dn0, 0);
    chk("c5_no_we", we_cnt - we0, 0);
    load_seed(8'hA5);
    run(4'hF, 4'h0, 1'b1, 0, 0, 0, d);
    tick();
    chk("c5_rerun_done", d, DONE_CYC);
    chk("c5_rerun_result", {24'd0, res}, 32'h56);

    load_seed(8'hA5);
    dn0 = done_cnt;
    run(4'hF, 4'h0, 1'b1, 0, 0, 5, d);
    tick();
    chk("c6_done_cyc", d, DONE_CYC);
    chk("c6_result", {24'd0, res}, 32'h56);
    chk("c6_final_row", {24'd0, shift_row}, 32'hFF);
    repeat (5) tick();
    chk("c6_no_rerun", done_cnt - dn0, 1);
    chk("c6_idle", {31'd0, busy}, 32'h0);

    expect_x = 0;
    for (int a = 0; a < 128; a++) expect_x += $countones(a ^ 32'hA5A5_0F0F);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cyc = 1;
    d = -1;
    while (cyc < 5000 && d < 0) begin
      if (done_b) d = cyc;
      else begin
        tick();
        cyc++;
      end
    end
    tick();
    chk("big_done_cyc", d, BIG_DONE);
    chk("big_row_all_ones", {31'd0, shift_row_b === {3072{1'b1}}}, 32'h1);
    chk("big_xor_count", xor_b_cnt, expect_x);
    chk("big_strobe_counts", {clr_b_cnt[15:0], we_b_cnt[15:0]}, {16'd1, 16'd1});
    chk("big_busy_after", {31'd0, busy_b}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
